booth_control: RTL and testbench

- Control unit for the 4-bit sequential Booth multiplier datapath.
- Sits directly upstream of the accumulator shift register (A), the multiplier register (Q), the Q(-1) flip-flop and the add/subtract ALU, and drives their load, shift and reset strobes.
- Sequences N Booth iterations from a start pulse, using the current Q[0]/Q(-1) pair, then flags completion.
- Moore FSM plus an iteration counter; it holds no datapath.

---
 rtl/booth_control.sv | 115 +++++++++++
 tb/tb_booth_control.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/booth_control.sv
// Sequencing FSM for a sequential Booth multiplier: steps A/Q/Q(-1)/M strobes
// through N add-or-subtract + shift iterations. All outputs decode from state only.
module booth_control #(
  parameter int N  = 4,
  parameter int CW = $clog2(N) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic q0,
  input  logic qm1,
  output logic ResetA,
  output logic CargaA,
  output logic DesplazaA,
  output logic CargaQ,
  output logic DesplazaQ,
  output logic CargaM,
  output logic ResetQm1,
  output logic DesplazaQm1,
  output logic SumRes,
  output logic Busy,
  output logic Fin
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_CHECK = 3'd2,
    S_ADD   = 3'd3,
    S_SUB   = 3'd4,
    S_SHIFT = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last = (r_count == CW'(N - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Iteration counter: cleared on every operation start, advanced once per shift.
  always_ff @(posedge clk) begin
    if (reset)                   r_count <= '0;
    else if (r_state == S_INIT)  r_count <= '0;
    else if (r_state == S_SHIFT) r_count <= r_count + CW'(1);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_INIT;
      S_INIT:  w_next = S_CHECK;
      S_CHECK: begin
        case ({q0, qm1})
          2'b10:   w_next = S_SUB;
          2'b01:   w_next = S_ADD;
          default: w_next = S_SHIFT;
        endcase
      end
      S_ADD:   w_next = S_SHIFT;
      S_SUB:   w_next = S_SHIFT;
      S_SHIFT: w_next = w_last ? S_DONE : S_CHECK;
      S_DONE:  if (start) w_next = S_INIT;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    ResetA      = 1'b0;
    CargaA      = 1'b0;
    DesplazaA   = 1'b0;
    CargaQ      = 1'b0;
    DesplazaQ   = 1'b0;
    CargaM      = 1'b0;
    ResetQm1    = 1'b0;
    DesplazaQm1 = 1'b0;
    SumRes      = 1'b0;
    Busy        = 1'b0;
    Fin         = 1'b0;
    case (r_state)
      S_INIT: begin
        ResetA   = 1'b1;
        CargaQ   = 1'b1;
        CargaM   = 1'b1;
        ResetQm1 = 1'b1;
        Busy     = 1'b1;
      end
      S_CHECK: Busy = 1'b1;
      S_ADD: begin
        CargaA = 1'b1;
        Busy   = 1'b1;
      end
      S_SUB: begin
        CargaA = 1'b1;
        SumRes = 1'b1;
        Busy   = 1'b1;
      end
      S_SHIFT: begin
        DesplazaA   = 1'b1;
        DesplazaQ   = 1'b1;
        DesplazaQm1 = 1'b1;
        Busy        = 1'b1;
      end
      S_DONE:  Fin = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_booth_control.sv
// Directed bench for booth_control: per-cycle strobe vectors, a small A/Q/M
// datapath model for the real multiply, and reset/restart corner cases.
module tb_booth_control;
  localparam int N = 4;

  logic clk = 1'b0;
  logic reset, start, q0, qm1;
  logic ResetA, CargaA, DesplazaA, CargaQ, DesplazaQ, CargaM;
  logic ResetQm1, DesplazaQm1, SumRes, Busy, Fin;

  booth_control #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start), .q0(q0), .qm1(qm1),
    .ResetA(ResetA), .CargaA(CargaA), .DesplazaA(DesplazaA),
    .CargaQ(CargaQ), .DesplazaQ(DesplazaQ), .CargaM(CargaM),
    .ResetQm1(ResetQm1), .DesplazaQm1(DesplazaQm1), .SumRes(SumRes),
    .Busy(Busy), .Fin(Fin)
  );

  always #5 clk = ~clk;

  // {ResetA,CargaA,DesplazaA,CargaQ,DesplazaQ,CargaM,ResetQm1,DesplazaQm1,SumRes,Busy,Fin}
  logic [10:0] outs;
  assign outs = {ResetA, CargaA, DesplazaA, CargaQ, DesplazaQ, CargaM,
                 ResetQm1, DesplazaQm1, SumRes, Busy, Fin};

  localparam logic [10:0] E_IDLE = 11'b0_0_0_0_0_0_0_0_0_0_0;
  localparam logic [10:0] E_INIT = 11'b1_0_0_1_0_1_1_0_0_1_0;
  localparam logic [10:0] E_CHK  = 11'b0_0_0_0_0_0_0_0_0_1_0;
  localparam logic [10:0] E_ADD  = 11'b0_1_0_0_0_0_0_0_0_1_0;
  localparam logic [10:0] E_SUB  = 11'b0_1_0_0_0_0_0_0_1_1_0;
  localparam logic [10:0] E_SHF  = 11'b0_0_1_0_1_0_0_1_0_1_0;
  localparam logic [10:0] E_DONE = 11'b0_0_0_0_0_0_0_0_0_0_1;

  // Behavioural datapath, used when dp_mode=1 to feed q0/qm1 back
  logic [3:0] A = '0, Q = '0, M = '0, mcand = '0, mult = '0;
  logic       Qm1 = 1'b0;
  bit         dp_mode = 1'b0;
  logic       q0_drv = 1'b0, qm1_drv = 1'b0;

  assign q0  = dp_mode ? Q[0] : q0_drv;
  assign qm1 = dp_mode ? Qm1  : qm1_drv;

  always @(posedge clk) begin
    if (ResetA)   A   <= '0;
    if (CargaQ)   Q   <= mult;
    if (CargaM)   M   <= mcand;
    if (ResetQm1) Qm1 <= 1'b0;
    if (CargaA)   A   <= SumRes ? (A - M) : (A + M);
    if (DesplazaA) begin
      A   <= {A[3], A[3:1]};
      Q   <= {A[0], Q[3:1]};
      Qm1 <= Q[0];
    end
  end

  int npass = 0, nfail = 0, ntot = 0;
  int nshift, ncarga, fin_cyc;
  logic [10:0] exq[$];
  logic [1:0]  pq[$];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntot++;
    assert (got === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected per-cycle vectors from the CHECK bit pairs (prs[1:0] = iteration 0).
  // pq[j] is what q0/qm1 carry during cycle j; outside CHECK it is the inverse pair.
  task automatic build(input logic [7:0] prs);
    logic [1:0] pr;
    exq = {};
    pq  = {};
    pq.push_back(2'b11);
    exq.push_back(E_INIT); pq.push_back(2'b10);
    for (int i = 0; i < N; i++) begin
      pr = prs[2*i +: 2];
      exq.push_back(E_CHK); pq.push_back(pr);
      if (pr == 2'b10)      begin exq.push_back(E_SUB); pq.push_back(~pr); end
      else if (pr == 2'b01) begin exq.push_back(E_ADD); pq.push_back(~pr); end
      exq.push_back(E_SHF); pq.push_back(~pr);
    end
    exq.push_back(E_DONE);
  endtask

  task automatic run_seq(input string tag, input logic [7:0] prs, input bit hold, input int poke);
    build(prs);
    nshift = 0; ncarga = 0; fin_cyc = -1;
    for (int j = 0; j < exq.size(); j++) begin
      start = (j == 0) || hold || (j == poke);
      {q0_drv, qm1_drv} = pq[j];
      step();
      if (DesplazaA) nshift++;
      if (CargaA) ncarga++;
      if (Fin && fin_cyc < 0) fin_cyc = j + 1;
      chk($sformatf("%s_c%0d", tag, j + 1), 32'(outs), 32'(exq[j]));
    end
    start = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    step(); chk("rst_c0", 32'(outs), 32'(E_IDLE));
    step(); chk("rst_c1", 32'(outs), 32'(E_IDLE));
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(); chk($sformatf("idle_%0d", i), 32'(outs), 32'(E_IDLE));
    end

    // No-op run: all pairs 00
    run_seq("noop", 8'b00_00_00_00, 1'b0, -1);
    chk("noop_shifts", nshift, 4);
    chk("noop_carga", ncarga, 0);
    chk("noop_fin", fin_cyc, 10);
    step(); chk("noop_stay_done", 32'(outs), 32'(E_DONE));

    // 3 x -2 through the datapath model
    dp_mode = 1'b1; mcand = 4'b0011; mult = 4'b1110;
    run_seq("mul", 8'b11_11_10_00, 1'b0, -1);
    chk("mul_fin", fin_cyc, 11);
    chk("mul_carga", ncarga, 1);
    chk("mul_AQ", 32'({A, Q}), 32'h0000_00FA);
    dp_mode = 1'b0;

    // Worst case: SUB, ADD, SUB, ADD
    run_seq("worst", 8'b01_10_01_10, 1'b0, -1);
    chk("worst_carga", ncarga, 4);
    chk("worst_fin", fin_cyc, 14);

    // Reset during the 2nd SHIFT
    start = 1'b1; {q0_drv, qm1_drv} = 2'b00;
    step(); start = 1'b0; chk("mrst_init", 32'(outs), 32'(E_INIT));
    step(); chk("mrst_chk1", 32'(outs), 32'(E_CHK));
    step(); chk("mrst_shf1", 32'(outs), 32'(E_SHF));
    step(); chk("mrst_chk2", 32'(outs), 32'(E_CHK));
    step(); chk("mrst_shf2", 32'(outs), 32'(E_SHF));
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("mrst_idle", 32'(outs), 32'(E_IDLE));
    chk("mrst_count", 32'(dut.r_count), 0);
    step(); chk("mrst_stay", 32'(outs), 32'(E_IDLE));
    run_seq("fresh", 8'b00_00_00_00, 1'b0, -1);
    chk("fresh_fin", fin_cyc, 10);

    // Reset during ADD drops the pending SHIFT
    start = 1'b1; {q0_drv, qm1_drv} = 2'b01;
    step(); start = 1'b0; chk("arst_init", 32'(outs), 32'(E_INIT));
    step(); chk("arst_chk", 32'(outs), 32'(E_CHK));
    step(); chk("arst_add", 32'(outs), 32'(E_ADD));
    reset = 1'b1;
    step(); reset = 1'b0;
    chk("arst_idle", 32'(outs), 32'(E_IDLE));
    step(); chk("arst_stay", 32'(outs), 32'(E_IDLE));

    // start held high: DONE goes straight back to INIT, Fin one cycle each run
    run_seq("b2b1", 8'b00_00_00_00, 1'b1, -1);
    chk("b2b1_fin", fin_cyc, 10);
    run_seq("b2b2", 8'b00_00_00_00, 1'b1, -1);
    chk("b2b2_fin", fin_cyc, 10);
    step(); chk("b2b_hold_done", 32'(outs), 32'(E_DONE));

    // start pulse while in CHECK (cycle 2) is ignored
    run_seq("poke", 8'b00_00_00_00, 1'b0, 2);
    chk("poke_fin", fin_cyc, 10);
    chk("poke_shifts", nshift, 4);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
